// File: rtl/bcd_seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver for a packed BCD value.
// The value is snapshotted once per frame; each slot starts with a blank guard.
module bcd_seg_scan_driver #(
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 2,
  parameter int BLANK_LEADING = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic        clk,
  input  logic        grst,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int   DW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    dp_sh_q, dp_sh_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;

  logic [3:0]    vis;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic [3:0]    an_act;
  logic [6:0]    seg_act;
  logic          dp_act;
  logic          wrap;
  logic          snap;

  // A digit is blanked only when it and every more significant digit are zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_vis
      if (gi == 0) begin : g_d0
        assign vis[gi] = 1'b1;
      end else begin : g_dk
        assign vis[gi] = (BLANK_LEADING == 0) || (shadow_q[15:4*gi] != '0);
      end
    end
  endgenerate

  assign nib = shadow_q[idx_q*4 +: 4];

  always_comb begin
    dec = 7'h40;
    case (nib)
      4'd0: dec = 7'h3F;
      4'd1: dec = 7'h06;
      4'd2: dec = 7'h5B;
      4'd3: dec = 7'h4F;
      4'd4: dec = 7'h66;
      4'd5: dec = 7'h6D;
      4'd6: dec = 7'h7D;
      4'd7: dec = 7'h07;
      4'd8: dec = 7'h7F;
      4'd9: dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  end

  always_comb begin
    wrap     = (div_q == DW'(REFRESH_DIV - 1));
    div_d    = wrap ? '0 : div_q + DW'(1);
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
    snap     = (div_q == '0) && (idx_q == 2'd0);
    shadow_d = snap ? bcd : shadow_q;
    dp_sh_d  = snap ? dp_in : dp_sh_q;
    tick_d   = snap;

    an_act  = 4'b0000;
    seg_act = 7'h00;
    dp_act  = 1'b0;
    if (div_q >= DW'(GUARD)) begin
      if (vis[idx_q] || dp_sh_q[idx_q]) an_act[idx_q] = 1'b1;
      if (vis[idx_q]) seg_act = dec;
      dp_act = dp_sh_q[idx_q];
    end
    an_d  = an_act ^ {4{POL}};
    seg_d = seg_act ^ {7{POL}};
    dp_d  = dp_act ^ POL;
  end

  always_ff @(posedge clk) begin
    if (!grst) begin
      div_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      dp_sh_q  <= 4'h0;
      an_q     <= {4{POL}};
      seg_q    <= {7{POL}};
      dp_q     <= POL;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      dp_sh_q  <= dp_sh_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// Bench for bcd_seg_scan_driver: two instances (leading-zero blanking on/off)
// compared every cycle against a frame-arithmetic reference model.
module tb_bcd_seg_scan_driver;

  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        grst = 1'b0;
  logic [15:0] bcd = 16'h0000;
  logic [3:0]  dp_in = 4'h0;

  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0, ft1, ft0;

  int checks = 0;
  int failures = 0;
  int t = 0;
  logic [15:0] m_sh = 16'h0000;
  logic [3:0]  m_dp = 4'h0;

  bcd_seg_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LEADING(1), .ACTIVE_LOW(1)) dut_bl1 (
    .clk(clk), .grst(grst), .bcd(bcd), .dp_in(dp_in),
    .an(an1), .seg(seg1), .dp(dp1), .frame_tick(ft1)
  );

  bcd_seg_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LEADING(0), .ACTIVE_LOW(1)) dut_bl0 (
    .clk(clk), .grst(grst), .bcd(bcd), .dp_in(dp_in),
    .an(an0), .seg(seg0), .dp(dp0), .frame_tick(ft0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (n > 4'd9) return 7'h40;
    return tbl[n];
  endfunction

  // Expected {an, seg, dp} (active-low) for the edge numbered tt after reset release.
  function automatic logic [11:0] model_out(input int tt, input logic [15:0] sh,
                                            input logic [3:0] dps, input bit bl);
    int pos, k;
    logic [15:0] upper;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    bit shown;
    pos = tt % RD;
    k = (tt / RD) % 4;
    if (pos < GD) return {4'hF, 7'h7F, 1'b1};
    upper = sh >> (4 * k);
    shown = (k == 0) || !bl || (upper != 16'h0000);
    an_e = 4'hF;
    if (shown || dps[k]) an_e[k] = 1'b0;
    seg_e = shown ? ~glyph(upper[3:0]) : 7'h7F;
    return {an_e, seg_e, ~dps[k]};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $display("FAIL %s t=%0d got=%h expected=%h", tag, t, obs, exp_v);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    logic [11:0] e1, e0;
    logic etick;
    @(posedge clk);
    if (!grst) begin
      e1 = {4'hF, 7'h7F, 1'b1};
      e0 = e1;
      etick = 1'b0;
      m_sh = 16'h0000;
      m_dp = 4'h0;
      t = 0;
    end else begin
      e1 = model_out(t, m_sh, m_dp, 1'b1);
      e0 = model_out(t, m_sh, m_dp, 1'b0);
      etick = ((t % FRAME) == 0);
      if (etick) begin
        m_sh = bcd;
        m_dp = dp_in;
        $display("snapshot t=%0d bcd=%h dp_in=%b", t, bcd, dp_in);
      end
      t++;
    end
    #1;
    check("an_bl1",   {4'h0, an1},  {4'h0, e1[11:8]});
    check("seg_bl1",  {1'b0, seg1}, {1'b0, e1[7:1]});
    check("dp_bl1",   {7'h0, dp1},  {7'h0, e1[0]});
    check("tick_bl1", {7'h0, ft1},  {7'h0, etick});
    check("an_bl0",   {4'h0, an0},  {4'h0, e0[11:8]});
    check("seg_bl0",  {1'b0, seg0}, {1'b0, e0[7:1]});
    check("dp_bl0",   {7'h0, dp0},  {7'h0, e0[0]});
    check("tick_bl0", {7'h0, ft0},  {7'h0, etick});
  endtask

  task automatic run(input logic [15:0] v, input logic [3:0] d, input int n);
    bcd = v;
    dp_in = d;
    repeat (n) step();
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    int mode;
    mode = $urandom_range(0, 2);
    v = 16'h0000;
    if (mode == 0) begin
      v = 16'($urandom);
    end else begin
      for (int i = 0; i < 4; i++)
        v[4*i +: 4] = 4'($urandom_range(0, 9));
      if (mode == 2) v = v >> (4 * $urandom_range(1, 3));
    end
    return v;
  endfunction

  initial begin
    grst = 1'b0;
    repeat (3) step();
    grst = 1'b1;

    run(16'h1234, 4'h0, 2 * FRAME);
    run(16'h0050, 4'h0, 2 * FRAME);
    run(16'h0000, 4'b0100, 2 * FRAME);
    run(16'h1111, 4'h0, FRAME + 2 * RD + 3);
    run(16'h2222, 4'h0, 2 * FRAME);
    run(16'h00B0, 4'h0, 2 * FRAME);

    for (int i = 0; i < 40; i++) begin
      run(rand_bcd(), 4'($urandom), $urandom_range(1, 45));
      if (i == 20) begin
        grst = 1'b0;
        repeat (2) step();
        grst = 1'b1;
      end
    end
    run(16'h9876, 4'b1001, 2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
